// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 slave responder, oversampled in clk; MSB-first,
// or LSB-first when SPI_LSB_FIRST_EN is defined.
module spi_slave_responder #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_WORD = {WIDTH{1'b1}},
    parameter int               SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso_out,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             busy
);
`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic [WIDTH-1:0]       hold, tx_sr, rx_sr, ld_word, ld_rest, sr_rest, rx_next;
    logic                   hold_full, ld_bit, sr_bit;
    logic [CW-1:0]          cnt;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                   accept, load, shift;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign tx_ready  = ~hold_full;
    assign accept    = tx_valid & ~hold_full;

    // cs_n rising has priority over any sclk edge seen in the same cycle
    always_comb begin
        load    = (state == IDLE) ? cs_fall : (!cs_rise && sclk_fall && cnt == '0);
        shift   = (state == ACTIVE) && !cs_rise && sclk_fall && cnt != '0;
        ld_word = hold_full ? hold : DEFAULT_WORD;
        ld_bit  = LSB_FIRST ? ld_word[0] : ld_word[WIDTH-1];
        ld_rest = LSB_FIRST ? ld_word >> 1 : ld_word << 1;
        sr_bit  = LSB_FIRST ? tx_sr[0] : tx_sr[WIDTH-1];
        sr_rest = LSB_FIRST ? tx_sr >> 1 : tx_sr << 1;
        rx_next = LSB_FIRST ? {mosi_s, rx_sr[WIDTH-1:1]} : {rx_sr[WIDTH-2:0], mosi_s};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            cnt         <= '0;
            miso_out    <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            // a load drains the holding register; a same-cycle accept refills it
            if (load) begin
                hold_full   <= 1'b0;
                tx_underrun <= ~hold_full;
                miso_out    <= ld_bit;
                tx_sr       <= ld_rest;
            end else if (shift) begin
                miso_out <= sr_bit;
                tx_sr    <= sr_rest;
            end
            if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
            if (state == IDLE) begin
                if (cs_fall) begin
                    state   <= ACTIVE;
                    miso_oe <= 1'b1;
                    busy    <= 1'b1;
                    cnt     <= '0;
                end
            end else if (cs_rise) begin
                state   <= IDLE;
                miso_oe <= 1'b0;
                busy    <= 1'b0;
                cnt     <= '0;
            end else if (sclk_rise) begin
                rx_sr <= rx_next;
                if (cnt == CW'(WIDTH - 1)) begin
                    cnt      <= '0;
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: directed SPI master stimulus against a word-level
// queue model of the responder (default MSB-first build).
module tb_spi_slave_responder;
    localparam logic [7:0] DEF = 8'hFF;

    logic       clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       miso_out, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;

    spi_slave_responder #(.WIDTH(8), .DEFAULT_WORD(DEF), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso_out(miso_out), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks = 0, failures = 0;
    logic [7:0] hold_q[$], exp_rx[$];
    logic       exp_miso[$];
    int         bits = 0, got_under = 0, rx_cnt = 0;
    logic [7:0] rx_acc = '0;
    logic [31:0] got_bits = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wclk(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // a word start takes the pending TX word, else the default word with an underrun
    task automatic start_word();
        logic [7:0] w;
        if (hold_q.size() != 0) w = hold_q.pop_front();
        else w = DEF;
        for (int i = 0; i < 8; i++) exp_miso.push_back(w[7-i]);
    endtask

    task automatic push_tx(logic [7:0] w);
        int t = 0;
        while (!tx_ready && t < 50) begin
            wclk(1);
            t++;
        end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        wclk(1);
        tx_valid = 1'b0;
        hold_q.push_back(w);
        wclk(1);
        chk("tx_ready_low", tx_ready, 0);
    endtask

    task automatic cs_start();
        got_bits = '0;
        bits     = 0;
        cs_n     = 1'b0;
        start_word();
        wclk(6);
        chk("oe_on", miso_oe, 1);
        chk("busy_on", busy, 1);
    endtask

    task automatic sclk_cycle(logic b, bit last);
        mosi = b;
        wclk(4);
        if (exp_miso.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL miso_extra: got %0b expected no bit", miso_out);
        end else begin
            chk("miso_bit", miso_out, exp_miso.pop_front());
        end
        got_bits = {got_bits[30:0], miso_out};
        sclk   = 1'b1;
        rx_acc = {rx_acc[6:0], b};
        bits++;
        if (bits % 8 == 0) exp_rx.push_back(rx_acc);
        wclk(8);
        if (!last) begin
            sclk = 1'b0;
            if (bits % 8 == 0) start_word();
            wclk(4);
        end
    endtask

    // cs_n rises together with the final sclk fall: the abort must win
    task automatic end_xfer();
        cs_n = 1'b1;
        sclk = 1'b0;
        exp_miso.delete();
        bits = 0;
        wclk(6);
        chk("oe_off", miso_oe, 0);
        chk("busy_off", busy, 0);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_miso_out"}, miso_out, 0);
        chk({tag, "_miso_oe"}, miso_oe, 0);
        chk({tag, "_tx_ready"}, tx_ready, 1);
        chk({tag, "_rx_data"}, rx_data, 0);
        chk({tag, "_rx_valid"}, rx_valid, 0);
        chk({tag, "_tx_underrun"}, tx_underrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    always @(negedge clk) begin
        if (tx_underrun) got_under++;
        if (rx_valid) begin
            rx_cnt++;
            if (exp_rx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected: got %0h expected no pulse", rx_data);
            end else begin
                chk("rx_data", rx_data, exp_rx.pop_front());
            end
        end
    end

    initial begin
        logic [7:0]  m;
        logic [15:0] m16;
        int          rx0, un0;
        wclk(2);
        chk_reset_vals("reset");
        rst = 1'b1;
        wclk(3);

        // preloaded word, single transfer
        rx0 = rx_cnt; un0 = got_under;
        push_tx(8'hA5);
        cs_start();
        chk("t1_tx_ready_after_load", tx_ready, 1);
        m = 8'h3C;
        for (int i = 0; i < 8; i++) sclk_cycle(m[7-i], i == 7);
        end_xfer();
        chk("t1_miso_word", got_bits[7:0], 32'hA5);
        chk("t1_rx_word", rx_data, 32'h3C);
        chk("t1_rx_pulses", rx_cnt - rx0, 1);
        chk("t1_underruns", got_under - un0, 0);

        // no preload: default word and one underrun
        rx0 = rx_cnt; un0 = got_under;
        cs_start();
        m = 8'h81;
        for (int i = 0; i < 8; i++) sclk_cycle(m[7-i], i == 7);
        end_xfer();
        chk("t2_miso_word", got_bits[7:0], 32'hFF);
        chk("t2_underruns", got_under - un0, 1);
        chk("t2_rx_word", rx_data, 32'h81);

        // back-to-back words with an accept during word 1
        rx0 = rx_cnt; un0 = got_under;
        push_tx(8'h11);
        cs_start();
        m16 = 16'hF00F;
        for (int i = 0; i < 2; i++) sclk_cycle(m16[15-i], 1'b0);
        push_tx(8'h22);
        for (int i = 2; i < 16; i++) sclk_cycle(m16[15-i], i == 15);
        end_xfer();
        chk("t3_miso_words", got_bits[15:0], 32'h1122);
        chk("t3_rx_pulses", rx_cnt - rx0, 2);
        chk("t3_rx_last", rx_data, 32'h0F);
        chk("t3_underruns", got_under - un0, 0);
        chk("t3_tx_ready", tx_ready, 1);

        // abort after 5 bits; holding word survives to the next transfer
        rx0 = rx_cnt; un0 = got_under;
        push_tx(8'h5A);
        cs_start();
        push_tx(8'hC3);
        for (int i = 0; i < 5; i++) sclk_cycle(1'b1, 1'b0);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("abort_oe_early", miso_oe, 1);
        @(posedge clk);
        #1 chk("abort_oe_latency", miso_oe, 0);
        exp_miso.delete();
        bits = 0;
        wclk(4);
        chk("t4_no_partial_rx", rx_cnt - rx0, 0);
        chk("t4_busy", busy, 0);
        cs_start();
        m = 8'h96;
        for (int i = 0; i < 8; i++) sclk_cycle(m[7-i], i == 7);
        end_xfer();
        chk("t4_miso_word", got_bits[7:0], 32'hC3);
        chk("t4_rx_word", rx_data, 32'h96);
        chk("t4_rx_pulses", rx_cnt - rx0, 1);
        chk("t4_underruns", got_under - un0, 0);

        // sclk with cs_n high is ignored
        rx0 = rx_cnt;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1;
            mosi = i[0];
            wclk(4);
            chk("t5_oe", miso_oe, 0);
            chk("t5_busy", busy, 0);
            sclk = 1'b0;
            wclk(4);
        end
        chk("t5_rx_pulses", rx_cnt - rx0, 0);

        // async reset mid-word discards the pending holding word
        push_tx(8'h77);
        cs_start();
        push_tx(8'h99);
        for (int i = 0; i < 3; i++) sclk_cycle(1'b1, 1'b0);
        #2 rst = 1'b0;
        #1 chk_reset_vals("async_reset");
        cs_n = 1'b1;
        sclk = 1'b0;
        hold_q.delete();
        exp_miso.delete();
        exp_rx.delete();
        bits = 0;
        wclk(2);
        rst = 1'b1;
        wclk(3);
        chk("t6_oe_idle", miso_oe, 0);
        un0 = got_under;
        cs_start();
        for (int i = 0; i < 8; i++) sclk_cycle(1'b0, i == 7);
        end_xfer();
        chk("t6_miso_word", got_bits[7:0], 32'hFF);
        chk("t6_underruns", got_under - un0, 1);
        chk("t6_rx_word", rx_data, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
